seq_chunk_adder: RTL and testbench
==================================

# seq_chunk_adder

Parametrised, multi-cycle successor to the 4-bit ripple-carry adder. It adds or subtracts two WIDTH-bit operands CHUNK bits per clock, LSB chunk first, carrying between chunks through an internal carry register. Results are registered and come with signed-overflow and carry flags. It sits on datapaths where a full-width single-cycle carry chain does not meet timing, and it uses a start/busy/done handshake.

## Interface
- WIDTH, 16, operand/result width in bits; must be an integer multiple of CHUNK.
- CHUNK, 4, bits processed per cycle; 1 ≤ CHUNK ≤ WIDTH. NCHUNK = WIDTH/CHUNK.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  request an operation; sampled only when idle.
- sub  in  1  0 = add, 1 = subtract; latched with start.
- a  in  WIDTH  operand A; latched with start.
- b  in  WIDTH  operand B; latched with start.
- c_in  in  1  carry-in (add) or borrow-in (sub); latched with start.
- busy  out  1  operation in progress.
- done  out  1  one-cycle completion pulse.
- sum  out  WIDTH  registered result.
- c_out  out  1  raw carry out of MSB; for sub, 1 = no borrow.
- ovf  out  1  two's-complement overflow.

## Operation
- States: IDLE, RUN.
- IDLE with start=1 at an edge:
  - Latch a into op_a.
  - Latch b, or ~b when sub=1, into op_b.
  - Load the carry register with c_in (add) or !c_in (sub).
  - Clear chunk counter cnt; set busy; go to RUN.
- Arithmetic:
  - add: sum = a + b + c_in.
  - sub: sum = a − b − c_in, implemented as a + ~b + !c_in.
  - Both are modulo 2^WIDTH.
- RUN, at each edge:
  - Compute chunk cnt of op_a + op_b + carry into an internal accumulator.
  - Update carry with that chunk's carry-out; increment cnt.
- Completion, on the edge processing chunk NCHUNK−1:
  - sum ← accumulator (all chunks).
  - c_out ← final carry.
  - ovf ← carry into MSB XOR carry out of MSB.
  - busy ← 0, done ← 1 for exactly one cycle; return to IDLE.
- Holding: sum, c_out and ovf hold their values until the next completion. They never show partial results.
- start while busy is ignored (no queueing). a, b, sub and c_in changes during RUN have no effect.
- NCHUNK = 1 (CHUNK = WIDTH) is legal and gives single-cycle RUN.

## Timing
- Reset (async assert, any state): state = IDLE, busy = 0, done = 0, sum = 0, c_out = 0, ovf = 0, cnt = 0, carry = 0. Any in-flight operation is discarded, with no done.
- Latency: start sampled at edge E0 → busy high from E0 to E_NCHUNK. done is high for the cycle after E_NCHUNK, with results valid in that same cycle.
- Throughput: one operation per NCHUNK+1 cycles worst case.
  - In the done cycle the block is already IDLE (busy = 0), so a start in that cycle is accepted.
  - Back-to-back operations therefore run every NCHUNK+1 edges.
- done and busy are never high together.
- Carry ripple is confined to CHUNK bits per cycle. The critical path is one CHUNK-bit add plus the carry register.

## Test plan
All cases use WIDTH=16, CHUNK=4 unless stated.

1. **Reset:** assert rst mid-cycle, without a clock edge → sum=0x0000, c_out=0, ovf=0, busy=0, done=0 immediately. Release rst; start a=0x1234, b=0x0FED, add, c_in=0 → busy for 4 edges, done pulse 1 cycle, sum=0x2221, c_out=0, ovf=0.
2. **Full-length carry chain:** 0xFFFF+0x0001 → sum=0x0000, c_out=1, ovf=0. 0x7FFF+0x0001 → sum=0x8000, c_out=0, ovf=1. 0x8000+0x8000 with c_in=1 → sum=0x0001, c_out=1, ovf=1.
3. **Subtract:**
   - 0x0005−0x0003 with c_in=0 → 0x0002, c_out=1.
   - 0x0003−0x0005 → 0xFFFE, c_out=0.
   - 0x8000−0x0001 → 0x7FFF, c_out=1, ovf=1.
   - 0x0005−0x0003 with c_in=1 → 0x0001.
4. **Handshake:**
   - Pulse start again while busy with different operands → ignored; the first result is unchanged.
   - Change a/b during RUN → no effect.
   - Assert start in the done cycle → the second op is accepted, and its done arrives 5 cycles after the first done.
   - Sum holds its value between operations.
5. **Reset mid-operation:** assert rst after 2 RUN edges → no done pulse, outputs cleared. Restart with 0x00FF+0x0001 → sum=0x0100.
6. **Legacy 4-bit vectors** (WIDTH=4, CHUNK=4, single-cycle RUN): 0000+0000 → 0000, c_out=0. 0101+0011 → 1000, c_out=0, ovf=1. 1010+0101 with c_in=1 → 0000, c_out=1. done follows 1 edge after start.

Source files
------------

// File: rtl/seq_chunk_adder.sv
// Multi-cycle adder/subtractor: CHUNK bits per clock, LSB chunk first, registered sum/c_out/ovf.
// Latency NCHUNK edges after start; start is ignored while busy, results hold until the next done.
module seq_chunk_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] acc;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic [CHUNK:0]   chunk_sum;
  logic [WIDTH-1:0] acc_next;
  logic             msb_cin;

  // Operands shift right each RUN edge so the active chunk is always the low CHUNK bits;
  // the accumulator fills from the top so after NCHUNK edges it holds the result in order.
  always_comb begin
    chunk_sum = {1'b0, op_a[CHUNK-1:0]} + {1'b0, op_b[CHUNK-1:0]} + {{CHUNK{1'b0}}, carry};
    acc_next  = (acc >> CHUNK) | (WIDTH'(chunk_sum[CHUNK-1:0]) << (WIDTH - CHUNK));
    msb_cin   = chunk_sum[CHUNK-1] ^ op_a[CHUNK-1] ^ op_b[CHUNK-1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      op_a  <= '0;
      op_b  <= '0;
      acc   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      c_out <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            op_a  <= a;
            op_b  <= sub ? ~b : b;
            carry <= sub ? ~c_in : c_in;
            acc   <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          op_a  <= op_a >> CHUNK;
          op_b  <= op_b >> CHUNK;
          carry <= chunk_sum[CHUNK];
          acc   <= acc_next;
          cnt   <= cnt + 1'b1;
          if (cnt == LAST) begin
            sum   <= acc_next;
            c_out <= chunk_sum[CHUNK];
            ovf   <= chunk_sum[CHUNK] ^ msb_cin;
            busy  <= 1'b0;
            done  <= 1'b1;
            cnt   <= '0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_chunk_adder.sv
// Directed bench for seq_chunk_adder: 16/4 instance plus a 4/4 legacy instance.
module tb_seq_chunk_adder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        start16 = 1'b0, sub16 = 1'b0, cin16 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0;
  logic        busy16, done16, c16, ovf16;
  logic [15:0] sum16;

  logic        start4 = 1'b0, sub4 = 1'b0, cin4 = 1'b0;
  logic [3:0]  a4 = '0, b4 = '0;
  logic        busy4, done4, c4, ovf4;
  logic [3:0]  sum4;

  int n_chk = 0, n_fail = 0, cyc = 0, t0 = 0;
  logic [15:0] last_sum = '0;

  typedef struct {logic [15:0] s; logic c; logic o;} exp_t;
  exp_t sb[$];

  seq_chunk_adder #(.WIDTH(16), .CHUNK(4)) u16 (
    .clk(clk), .rst(rst), .start(start16), .sub(sub16), .a(a16), .b(b16), .c_in(cin16),
    .busy(busy16), .done(done16), .sum(sum16), .c_out(c16), .ovf(ovf16));

  seq_chunk_adder #(.WIDTH(4), .CHUNK(4)) u4 (
    .clk(clk), .rst(rst), .start(start4), .sub(sub4), .a(a4), .b(b4), .c_in(cin4),
    .busy(busy4), .done(done4), .sum(sum4), .c_out(c4), .ovf(ovf4));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model16(input logic [15:0] a, input logic [15:0] b,
                                   input logic s, input logic ci);
    exp_t        e;
    logic [15:0] bb;
    logic [16:0] r;
    bb  = s ? ~b : b;
    r   = {1'b0, a} + {1'b0, bb} + 17'(s ? !ci : ci);
    e.s = r[15:0];
    e.c = r[16];
    e.o = (a[15] == bb[15]) && (r[15] != a[15]);
    return e;
  endfunction

  task automatic expect16(input logic [15:0] s, input logic c, input logic o);
    exp_t e;
    e.s = s; e.c = c; e.o = o;
    sb.push_back(e);
  endtask

  // Leaves the bench at the falling edge after the accepting edge E0.
  task automatic go16(input logic [15:0] a, input logic [15:0] b, input logic s, input logic ci);
    @(negedge clk);
    a16 = a; b16 = b; sub16 = s; cin16 = ci; start16 = 1'b1;
    @(negedge clk);
    start16 = 1'b0;
    t0 = cyc;
    check("busy_after_start", busy16, 1);
  endtask

  // Waits for done (bounded), then compares against the oldest scoreboard entry.
  task automatic wait16();
    exp_t e;
    int   n = 0;
    while (!done16 && n < 40) begin
      check("busy_while_running", busy16, 1);
      @(negedge clk);
      n++;
    end
    if (!done16) check("done_timeout", 0, 1);
    e = sb.pop_front();
    check("latency", cyc - t0, 4);
    check("sum", sum16, e.s);
    check("c_out", c16, e.c);
    check("ovf", ovf16, e.o);
    check("busy_in_done_cycle", busy16, 0);
    last_sum = e.s;
  endtask

  task automatic end16();
    @(negedge clk);
    check("done_one_cycle", done16, 0);
    repeat (2) @(negedge clk);
    check("sum_holds", sum16, last_sum);
  endtask

  task automatic run4(input logic [3:0] a, input logic [3:0] b, input logic ci,
                      input logic [3:0] es, input logic ec, input logic eo);
    int n = 0;
    int ts;
    @(negedge clk);
    a4 = a; b4 = b; cin4 = ci; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    ts = cyc;
    while (!done4 && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("legacy_latency", cyc - ts, 1);
    check("legacy_sum", sum4, es);
    check("legacy_c_out", c4, ec);
    check("legacy_ovf", ovf4, eo);
    check("legacy_busy", busy4, 0);
  endtask

  initial begin
    int   saw;
    int   d1;
    exp_t e;
    logic [15:0] ra, rb;
    logic rs, rc;

    repeat (2) @(negedge clk);
    check("rst_busy", busy16, 0);
    check("rst_done", done16, 0);
    check("rst_sum", sum16, 16'h0000);
    rst = 1'b0;

    // Load a nonzero result, then reset between clock edges.
    go16(16'h1111, 16'h1111, 1'b0, 1'b0);
    expect16(16'h2222, 1'b0, 1'b0);
    wait16();
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("async_rst_sum", sum16, 16'h0000);
    check("async_rst_c_out", c16, 0);
    check("async_rst_ovf", ovf16, 0);
    check("async_rst_busy", busy16, 0);
    check("async_rst_done", done16, 0);
    @(negedge clk);
    rst = 1'b0;

    go16(16'h1234, 16'h0FED, 1'b0, 1'b0); expect16(16'h2221, 1'b0, 1'b0); wait16(); end16();

    // Full-length carry chains.
    go16(16'hFFFF, 16'h0001, 1'b0, 1'b0); expect16(16'h0000, 1'b1, 1'b0); wait16(); end16();
    go16(16'h7FFF, 16'h0001, 1'b0, 1'b0); expect16(16'h8000, 1'b0, 1'b1); wait16(); end16();
    go16(16'h8000, 16'h8000, 1'b0, 1'b1); expect16(16'h0001, 1'b1, 1'b1); wait16(); end16();

    // Subtract.
    go16(16'h0005, 16'h0003, 1'b1, 1'b0); expect16(16'h0002, 1'b1, 1'b0); wait16(); end16();
    go16(16'h0003, 16'h0005, 1'b1, 1'b0); expect16(16'hFFFE, 1'b0, 1'b0); wait16(); end16();
    go16(16'h8000, 16'h0001, 1'b1, 1'b0); expect16(16'h7FFF, 1'b1, 1'b1); wait16(); end16();
    go16(16'h0005, 16'h0003, 1'b1, 1'b1); expect16(16'h0001, 1'b1, 1'b0); wait16(); end16();

    // start and operand changes while busy are ignored.
    go16(16'h0100, 16'h0200, 1'b0, 1'b0);
    expect16(16'h0300, 1'b0, 1'b0);
    a16 = 16'hFFFF; b16 = 16'hFFFF; sub16 = 1'b1; cin16 = 1'b1; start16 = 1'b1;
    @(negedge clk);
    start16 = 1'b0; a16 = 16'hAAAA; b16 = 16'h5555;
    wait16();
    end16();

    // Start accepted in the done cycle.
    go16(16'h0001, 16'h0002, 1'b0, 1'b0);
    expect16(16'h0003, 1'b0, 1'b0);
    wait16();
    d1 = cyc;
    a16 = 16'h0010; b16 = 16'h0020; sub16 = 1'b0; cin16 = 1'b0; start16 = 1'b1;
    expect16(16'h0030, 1'b0, 1'b0);
    @(negedge clk);
    start16 = 1'b0;
    t0 = cyc;
    check("b2b_done_dropped", done16, 0);
    check("b2b_busy", busy16, 1);
    check("b2b_sum_held", sum16, 16'h0003);
    wait16();
    check("b2b_done_spacing", cyc - d1, 5);
    end16();

    // Reset after two RUN edges discards the operation.
    go16(16'h1111, 16'h2222, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("midop_rst_busy", busy16, 0);
    check("midop_rst_sum", sum16, 16'h0000);
    check("midop_rst_c_out", c16, 0);
    @(negedge clk);
    rst = 1'b0;
    saw = 0;
    repeat (8) begin
      @(negedge clk);
      if (done16) saw++;
    end
    check("midop_no_done", saw, 0);
    go16(16'h00FF, 16'h0001, 1'b0, 1'b0); expect16(16'h0100, 1'b0, 1'b0); wait16(); end16();

    // Random operands against the reference model.
    for (int i = 0; i < 6; i++) begin
      ra = 16'($urandom); rb = 16'($urandom);
      rs = 1'($urandom_range(0, 1)); rc = 1'($urandom_range(0, 1));
      e = model16(ra, rb, rs, rc);
      go16(ra, rb, rs, rc);
      expect16(e.s, e.c, e.o);
      wait16();
    end

    // Legacy single-chunk configuration.
    run4(4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0);
    run4(4'b0101, 4'b0011, 1'b0, 4'b1000, 1'b0, 1'b1);
    run4(4'b1010, 4'b0101, 1'b1, 4'b0000, 1'b1, 1'b0);

    check("scoreboard_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
